// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port image memory between VGA fetch, host LOAD/STORE and the
// zoom engine, returning read data tagged by requester and blanking VGA during a zoom.
module mem_port_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  input  logic              alg_req,
  input  logic              alg_we,
  input  logic [ADDR_W-1:0] alg_addr,
  input  logic [DATA_W-1:0] alg_wdata,
  output logic              alg_gnt,
  input  logic              alg_lock,
  output logic [1:0]        rd_rvalid,
  output logic [DATA_W-1:0] rd_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic [1:0]        owner
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_VGA  = 2'd1;
  localparam logic [1:0] OWN_HOST = 2'd2;
  localparam logic [1:0] OWN_ALG  = 2'd3;
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  typedef struct packed {
    logic [1:0] own;
    logic       blank;
  } rd_tag_t;

  // Handshake: a requester holds req with its command until the cycle its gnt pulses;
  // whatever it presents during that gnt cycle is already its next request, so a
  // requester can stream one access per cycle by updating its command on each gnt.
  logic       vga_eligible;
  logic       vga_blank;
  logic       starve;
  logic [1:0] win;
  logic       win_is_read;
  logic [7:0] starve_cnt;
  rd_tag_t    issue_tag;
  rd_tag_t    tag_out;
  rd_tag_t    tag_pipe [RD_LATENCY+1];

  always_comb begin
    vga_eligible = vga_req & ~alg_lock;
    vga_blank    = vga_req & alg_lock;
    starve       = (starve_cnt == STARVE_LIM);
    win          = OWN_NONE;
    if (vga_eligible)
      win = OWN_VGA;
    else if (alg_req && (starve || !host_req))
      win = OWN_ALG;
    else if (host_req)
      win = OWN_HOST;
    win_is_read = (win == OWN_VGA) ||
                  ((win == OWN_HOST) && !host_we) ||
                  ((win == OWN_ALG) && !alg_we);
    issue_tag.own   = win_is_read ? win : OWN_NONE;
    issue_tag.blank = vga_blank;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vga_gnt    <= 1'b0;
      host_gnt   <= 1'b0;
      alg_gnt    <= 1'b0;
      owner      <= OWN_NONE;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_wren   <= 1'b0;
      starve_cnt <= '0;
      for (int i = 0; i <= RD_LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      // A blanked VGA read is acknowledged without taking the memory slot.
      vga_gnt  <= (win == OWN_VGA) | vga_blank;
      host_gnt <= (win == OWN_HOST);
      alg_gnt  <= (win == OWN_ALG);
      owner    <= win;
      case (win)
        OWN_VGA: begin
          mem_addr <= vga_addr;
          mem_wren <= 1'b0;
        end
        OWN_HOST: begin
          mem_addr <= host_addr;
          mem_data <= host_wdata;
          mem_wren <= host_we;
        end
        OWN_ALG: begin
          mem_addr <= alg_addr;
          mem_data <= alg_wdata;
          mem_wren <= alg_we;
        end
        default: mem_wren <= 1'b0;
      endcase
      tag_pipe[0] <= issue_tag;
      for (int i = 1; i <= RD_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
      if (!alg_req || (win == OWN_ALG))
        starve_cnt <= '0;
      else if (!starve)
        starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // The last tag stage lines up with the cycle mem_q carries that access's data.
  assign tag_out    = tag_pipe[RD_LATENCY];
  assign vga_rvalid = (tag_out.own == OWN_VGA) | tag_out.blank;
  assign vga_rdata  = (tag_out.own == OWN_VGA) ? mem_q : '0;
  assign rd_rvalid  = {tag_out.own == OWN_ALG, tag_out.own == OWN_HOST};
  assign rd_rdata   = (rd_rvalid != 2'b00) ? mem_q : '0;

endmodule
